// File: rtl/alu_pkg.sv
// =============================================================================
// Module   : alu_pkg
// Brief    : ALU opcode encodings shared by the ALU control and execute stages.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// =============================================================================
// Module   : alu_core
// Brief    : Combinational ALU datapath producing result, zero and overflow.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_overflow
);

    localparam int c_MSB = WIDTH - 1;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_lt;
    logic             w_add_ovf;
    logic             w_sub_ovf;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    // Direct signed compare rather than the sign of w_diff, so SLT stays
    // correct when a-b overflows.
    assign w_lt = ($signed(i_a) < $signed(i_b));

    assign w_add_ovf = (i_a[c_MSB] == i_b[c_MSB]) && (w_sum[c_MSB]  != i_a[c_MSB]);
    assign w_sub_ovf = (i_a[c_MSB] != i_b[c_MSB]) && (w_diff[c_MSB] != i_a[c_MSB]);

    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        case (i_op)
            ALU_ADD: begin
                o_result   = w_sum;
                o_overflow = w_add_ovf;
            end
            ALU_SUB: begin
                o_result   = w_diff;
                o_overflow = w_sub_ovf;
            end
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_SLT: o_result = {{(WIDTH-1){1'b0}}, w_lt};
            default: begin
                o_result   = '0;
                o_overflow = 1'b0;
            end
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

`default_nettype wire

// File: rtl/ex_alu_stage.sv
// =============================================================================
// Module   : ex_alu_stage
// Brief    : Registered execute-stage ALU with stall/flush and overflow counter.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module ex_alu_stage
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int OVF_CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    input  logic [2:0]           ALU_control,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     result,
    output logic                 zero,
    output logic                 overflow,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    localparam logic [OVF_CNT_W-1:0] c_OVF_MAX = '1;

    logic [WIDTH-1:0]     w_result;
    logic                 w_zero;
    logic                 w_overflow;
    logic                 w_load;
    logic                 w_count;

    logic                 r_valid;
    logic [WIDTH-1:0]     r_result;
    logic                 r_zero;
    logic                 r_overflow;
    logic [OVF_CNT_W-1:0] r_ovf_count;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .i_op       (ALU_control),
        .i_a        (op_a),
        .i_b        (op_b),
        .o_result   (w_result),
        .o_zero     (w_zero),
        .o_overflow (w_overflow)
    );

    assign w_load  = !flush && !stall;
    assign w_count = w_load && in_valid && w_overflow && (r_ovf_count != c_OVF_MAX);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid     <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_ovf_count <= '0;
        end else begin
            if (flush) begin
                r_valid    <= 1'b0;
                r_result   <= '0;
                r_zero     <= 1'b0;
                r_overflow <= 1'b0;
            end else if (!stall) begin
                // An empty slot carries all-zero data, including the zero flag.
                r_valid    <= in_valid;
                r_result   <= in_valid ? w_result : '0;
                r_zero     <= in_valid && w_zero;
                r_overflow <= in_valid && w_overflow;
            end
            if (w_count) begin
                r_ovf_count <= r_ovf_count + 1'b1;
            end
        end
    end

    assign out_valid = r_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_overflow;
    assign ovf_count = r_ovf_count;

endmodule

`default_nettype wire

// File: tb/tb_ex_alu_stage.sv
// =============================================================================
// Module   : tb_ex_alu_stage
// Brief    : Directed self-checking bench for ex_alu_stage (default and 2-bit counter).
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_ex_alu_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic [2:0]  ALU_control;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        stall;
    logic        flush;

    logic        out_valid, zero, overflow;
    logic [31:0] result;
    logic [7:0]  ovf_count;

    logic        s_out_valid, s_zero, s_overflow;
    logic [31:0] s_result;
    logic [1:0]  s_ovf_count;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    ex_alu_stage #(.WIDTH(32), .OVF_CNT_W(8)) u_dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .ALU_control(ALU_control),
        .op_a(op_a), .op_b(op_b), .stall(stall), .flush(flush),
        .out_valid(out_valid), .result(result), .zero(zero),
        .overflow(overflow), .ovf_count(ovf_count)
    );

    ex_alu_stage #(.WIDTH(32), .OVF_CNT_W(2)) u_sat (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .ALU_control(ALU_control),
        .op_a(op_a), .op_b(op_b), .stall(stall), .flush(flush),
        .out_valid(s_out_valid), .result(s_result), .zero(s_zero),
        .overflow(s_overflow), .ovf_count(s_ovf_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid    = v;
        ALU_control = op;
        op_a        = a;
        op_b        = b;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] r,
                           input logic z, input logic o);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".result"}, 64'(result), 64'(r));
        chk({tag, ".zero"}, 64'(zero), 64'(z));
        chk({tag, ".ovf"}, 64'(overflow), 64'(o));
    endtask

    initial begin
        RST = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 3'b010, 32'h7FFF_FFFF, 32'h1);
        tick();
        chk_out("reset", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("reset.cnt", 64'(ovf_count), 64'd0);
        RST = 1'b0;

        // ADD overflow
        tick();
        chk_out("add_ovf", 1'b1, 32'h8000_0000, 1'b0, 1'b1);
        chk("add_ovf.cnt", 64'(ovf_count), 64'd1);

        // SUB to zero
        drive(1'b1, 3'b110, 32'h1234, 32'h1234);
        tick();
        chk_out("sub_zero", 1'b1, 32'h0, 1'b1, 1'b0);

        // SLT where a-b overflows, then swapped
        drive(1'b1, 3'b111, 32'h8000_0000, 32'h1);
        tick();
        chk_out("slt_lt", 1'b1, 32'h1, 1'b0, 1'b0);
        drive(1'b1, 3'b111, 32'h1, 32'h8000_0000);
        tick();
        chk_out("slt_ge", 1'b1, 32'h0, 1'b1, 1'b0);

        drive(1'b1, 3'b001, 32'hF0, 32'h0F);
        tick();
        chk_out("or", 1'b1, 32'hFF, 1'b0, 1'b0);

        // SUB overflow: most negative minus one
        drive(1'b1, 3'b110, 32'h8000_0000, 32'h1);
        tick();
        chk_out("sub_ovf", 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        chk("sub_ovf.cnt", 64'(ovf_count), 64'd2);

        // ADD wraps without signed overflow
        drive(1'b1, 3'b010, 32'hFFFF_FFFF, 32'h1);
        tick();
        chk_out("add_wrap", 1'b1, 32'h0, 1'b1, 1'b0);

        // Invalid slot: data zeroed, not counted
        drive(1'b0, 3'b010, 32'h7FFF_FFFF, 32'h1);
        tick();
        chk_out("bubble", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("bubble.cnt", 64'(ovf_count), 64'd2);

        // Stall holds AND result while inputs change
        drive(1'b1, 3'b000, 32'hF0F0, 32'hFF00);
        tick();
        chk_out("and", 1'b1, 32'hF000, 1'b0, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'b010, 32'h7FFF_FFFF, 32'(i + 1));
            tick();
            chk_out("stall_hold", 1'b1, 32'hF000, 1'b0, 1'b0);
            chk("stall_hold.cnt", 64'(ovf_count), 64'd2);
        end
        flush = 1'b1;
        tick();
        chk_out("flush_stall", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("flush_stall.cnt", 64'(ovf_count), 64'd2);
        stall = 1'b0;
        tick();
        chk_out("flush_only", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("flush_only.cnt", 64'(ovf_count), 64'd2);
        flush = 1'b0;

        // Saturation on the 2-bit counter instance
        RST = 1'b1;
        tick();
        chk("sat_reset.cnt", 64'(s_ovf_count), 64'd0);
        RST = 1'b0;
        drive(1'b1, 3'b010, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("sat.cnt", 64'(s_ovf_count), 64'((i > 3) ? 3 : i));
            chk("sat.main_cnt", 64'(ovf_count), 64'(i));
            chk("sat.ovf", 64'(s_overflow), 64'd1);
        end

        // Held overflow entry counted only once
        stall = 1'b1;
        tick();
        tick();
        chk("stall_ovf.cnt", 64'(ovf_count), 64'd5);
        chk("stall_ovf.ovf", 64'(overflow), 64'd1);

        // Reset wins mid-stall
        RST = 1'b1;
        tick();
        chk_out("rst_stall", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst_stall.cnt", 64'(ovf_count), 64'd0);
        chk("rst_stall.scnt", 64'(s_ovf_count), 64'd0);
        RST = 1'b0;
        stall = 1'b0;

        // Undefined opcodes
        drive(1'b1, 3'b101, 32'h5, 32'h3);
        tick();
        chk_out("op101", 1'b1, 32'h0, 1'b1, 1'b0);
        drive(1'b1, 3'b011, 32'h7FFF_FFFF, 32'h1);
        tick();
        chk_out("op011", 1'b1, 32'h0, 1'b1, 1'b0);
        chk("op011.cnt", 64'(ovf_count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/ex_alu_stage.md
EX_ALU_STAGE -- requirements
Module: ex_alu_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have parameter OVF_CNT_W, default 8: width of the saturating overflow counter.
REQ-003 SHALL have port CLK, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port RST, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: ALU_control/operands valid this cycle.
REQ-006 SHALL have port ALU_control, input, 3: operation code from ALU control stage.
REQ-007 SHALL have ports op_a and op_b, input, WIDTH each: operands, aligned with ALU_control by the upstream stage.
REQ-008 SHALL have port stall, input, 1: hold the output register.
REQ-009 SHALL have port flush, input, 1: kill the output register contents.
REQ-010 SHALL have port out_valid, output, 1: result register holds a live result.
REQ-011 SHALL have port result, output, WIDTH: registered ALU result.
REQ-012 SHALL have port zero, output, 1: registered (result == 0) flag.
REQ-013 SHALL have port overflow, output, 1: registered signed overflow for ADD/SUB.
REQ-014 SHALL have port ovf_count, output, OVF_CNT_W: saturating count of accepted overflowing ops.

Function
REQ-015 SHALL decode ALU_control as: 010 ADD, 110 SUB (a-b), 000 AND, 001 OR, 111 SLT (signed a<b -> 1, else 0).
REQ-016 SHALL produce result 0, zero 1, overflow 0 for any other ALU_control value (011, 100, 101).
REQ-017 SHALL have a latency of exactly one cycle: inputs sampled at edge N appear on the outputs after edge N.
REQ-018 SHALL compute overflow for ADD as sign(a)==sign(b) and sign(sum)!=sign(a); for SUB as sign(a)!=sign(b) and sign(diff)!=sign(a); 0 for all other ops.
REQ-019 SHALL compute SLT from the true signed comparison, correct even when a-b overflows.
REQ-020 SHALL wrap ADD/SUB results modulo 2^WIDTH.
REQ-021 SHALL, with stall=0 and flush=0, load result/zero/overflow from the inputs and set out_valid=in_valid.
REQ-022 SHALL hold result, zero, overflow and out_valid unchanged when stall=1 and flush=0, ignoring the inputs.
REQ-023 SHALL clear out_valid, result, zero and overflow to 0 when flush=1, regardless of stall; flush has priority over stall.
REQ-024 SHALL zero the data outputs (result=0, zero=0, overflow=0) whenever in_valid=0 is loaded.
REQ-025 SHALL increment ovf_count by 1 on each edge where a new entry with in_valid=1 and overflow=1 is loaded, i.e. not stalled and not flushed.
REQ-026 SHALL saturate ovf_count at 2^OVF_CNT_W-1 and never wrap.
REQ-027 SHALL not count overflow on a held (stalled) entry more than once.

Reset
REQ-028 SHALL, when RST=1 at a rising edge, set out_valid=0, result=0, zero=0, overflow=0 and ovf_count=0.
REQ-029 SHALL give RST priority over flush, stall and in_valid, including mid-stall.
REQ-030 SHALL resume normal loading on the first edge after RST deasserts.

Structure
REQ-031 SHALL take the opcode constants (ADD, SUB, AND, OR, SLT) from a shared package, alu_pkg, also used by the ALU control stage.
REQ-032 SHALL place the combinational datapath (operations, zero, overflow) in one sub-module, alu_core; ex_alu_stage holds only registers, stall/flush/valid logic and the counter.

Verification
REQ-033 SHALL be verified by a directed ADD overflow case: WIDTH=32, ALU_control=010, a=0x7FFFFFFF, b=1, in_valid=1 -> next cycle result=0x80000000, overflow=1, zero=0, ovf_count=1.
REQ-034 SHALL be verified by a directed SUB/zero case: 110, a=b=0x1234 -> result=0, zero=1, overflow=0.
REQ-035 SHALL be verified by a directed SLT overflow case: 111, a=0x80000000, b=1 -> result=1; swapped operands -> result=0.
REQ-036 SHALL be verified by a directed stall/flush case: load AND 0xF0F0 & 0xFF00, then stall=1 for 3 cycles with changing inputs -> result stays 0xF000; then flush=1 with stall=1 -> out_valid=0, result=0.
REQ-037 SHALL be verified by a directed saturation case: OVF_CNT_W=2, 5 consecutive overflowing ADDs -> ovf_count 1,2,3,3,3; a stalled overflow entry does not increment.
REQ-038 SHALL be verified by a directed reset/undefined-op case: RST=1 during stall -> all outputs 0 next cycle; ALU_control=101 -> result=0, zero=1.
